morse_keyer: RTL
================

# morse_keyer

Serial Morse keyer that sits directly downstream of the binary-to-Morse encoder. It captures one 5-symbol digit code (s1..s5, 1 = dot, 0 = dash, s1 sent first) through a valid/ready handshake. It then drives a single key line with standard Morse timing: dot, dash, intra-character gap and inter-character gap. It is the block that turns the encoder's parallel code into a timed on/off signal for a buzzer, LED or line driver.

## Interface
- UNIT_CYCLES, default 4: clock cycles per Morse time unit; legal range 1..65535.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- s1..s5  input  1 each  symbol code from encoder; 1 = dot, 0 = dash; s1 keyed first.
- in_valid  input  1  code on s1..s5 is valid (driven from encoder `ready`).
- in_ready  output  1  keyer can accept a code; high only in IDLE.
- abort  input  1  synchronous; drops the current character.
- key  output  1  Morse line; 1 = tone/mark.
- busy  output  1  character in progress; equals !in_ready.
- done  output  1  one-cycle pulse at end of character.

## Operation
- States: IDLE, MARK, GAP, CHAR_GAP.
- IDLE:
  - in_ready=1, key=0.
  - On a clk edge with in_valid & in_ready: latch s1..s5 into a 5-bit shift register, set symbol index to 0, go to MARK.
- MARK:
  - key=1.
  - Duration is 1 unit for a dot and 3 units for a dash.
  - At the end: go to GAP if index < 4, else go to CHAR_GAP.
- GAP:
  - key=0 for 1 unit.
  - Then increment index, shift the register, and return to MARK.
- CHAR_GAP:
  - key=0 for 3 units.
  - done=1 on the last cycle of CHAR_GAP; the next state is IDLE.
- abort:
  - In any non-IDLE state, abort=1 at a clk edge gives next state IDLE, key=0, done=0, latched code discarded.
  - abort is ignored in IDLE; if in_valid and abort are both high in IDLE, the code is accepted.
- in_valid while busy is ignored. No queuing; the code is not re-sampled mid-character.
- Counters:
  - The prescaler counts 0..UNIT_CYCLES-1 and produces a unit tick on its terminal count.
  - The unit counter is 2 bits and counts to 1 or 3 units.
  - The symbol index is 3 bits.
  - The prescaler and unit counter clear on every state change, so each state starts on a fresh unit boundary.
- Reset (asynchronous, mid-operation included): state=IDLE, key=0, busy=0, done=0, in_ready=1, all counters and the shift register cleared.

## Timing
- key, done and busy are registered. in_ready is decoded from the state register.
- Accept edge N gives key=1 from cycle N+1.
- Durations (U = UNIT_CYCLES):
  - dot mark: exactly U cycles.
  - dash mark: 3U cycles.
  - each gap: U cycles.
  - char gap: 3U cycles.
- Character length from accept edge to in_ready high = (dots + 3·dashes + 4 + 3)·U cycles.
  - Digit 5 (all dots): 12U.
  - Digit 0 (all dashes): 22U.
- done is high for the final cycle of CHAR_GAP. in_ready rises the following cycle.
- Back-to-back: a new code can be accepted on the first IDLE cycle, so there is zero dead time beyond the char gap.
- UNIT_CYCLES=1 must work: every unit is one cycle.

## Structure
- Package morse_pkg holds:
  - the state enum (IDLE, MARK, GAP, CHAR_GAP);
  - constants DOT=1'b1, DASH=1'b0;
  - DASH_UNITS=3, GAP_UNITS=1, CHAR_GAP_UNITS=3;
  - SYMBOLS_PER_CHAR=5.
- Sub-module morse_unit_timer:
  - the prescaler plus unit counter;
  - inputs: restart, target_units;
  - output: expired;
  - parameterised by UNIT_CYCLES.
- The top holds the FSM, the shift register and the output registers.

## Test plan
- U=4, code 11111 (digit 5): key=1 for 4 cycles, 5 times, separated by 4-cycle lows. done pulses at cycle 48 after accept; in_ready high at 49.
- U=4, code 00000 (digit 0): five 12-cycle marks. done at cycle 88.
- U=1, code 00001 (digit 9): key pattern 111 0 111 0 111 0 111 0 1 then 000; done on the last 0 (cycle 20).
- Two codes with in_valid held high (5 then 0): second code accepted on the first IDLE cycle after done. in_valid toggling during busy does not change key.
- Reset driven low mid-dash (cycle 6 of a 12-cycle mark): key=0 and in_ready=1 immediately, without a clock edge. After release, digit 5 keys normally.
- abort=1 during the GAP after symbol 2: IDLE on the next cycle, key=0, no done pulse.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse keyer.
// Unit counts are 2 bits wide because no element lasts longer than 3 units.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MARK     = 2'd1,
    GAP      = 2'd2,
    CHAR_GAP = 2'd3
  } morse_state_t;

  localparam logic DOT  = 1'b1;
  localparam logic DASH = 1'b0;

  localparam logic [1:0] DOT_UNITS      = 2'd1;
  localparam logic [1:0] DASH_UNITS     = 2'd3;
  localparam logic [1:0] GAP_UNITS      = 2'd1;
  localparam logic [1:0] CHAR_GAP_UNITS = 2'd3;

  localparam int         SYMBOLS_PER_CHAR = 5;
  localparam logic [2:0] LAST_SYMBOL      = 3'(SYMBOLS_PER_CHAR - 1);

  function automatic logic [1:0] mark_units(input logic sym);
    logic [1:0] units;
    units = DOT_UNITS;
    case (sym)
      DOT:  units = DOT_UNITS;
      DASH: units = DASH_UNITS;
      default: units = DOT_UNITS;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Prescaler plus unit counter that times one keyer state.
// almost_expired flags the cycle before expiry so the top can register done.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic [1:0] target_units,
  output logic       expired,
  output logic       almost_expired
);

  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(UNIT_CYCLES - 1);

  logic [PW-1:0] pcnt;
  logic [1:0]    ucnt;
  logic          unit_tick;

  assign unit_tick = (pcnt == P_LAST);
  assign expired   = unit_tick && (ucnt == target_units - 2'd1);

  // With one-cycle units the penultimate cycle sits in the previous unit.
  if (UNIT_CYCLES == 1) begin : g_single
    assign almost_expired = (ucnt == target_units - 2'd2);
  end else begin : g_multi
    localparam logic [PW-1:0] P_PREV = PW'(UNIT_CYCLES - 2);
    assign almost_expired = (pcnt == P_PREV) && (ucnt == target_units - 2'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
      ucnt <= '0;
    end else if (restart) begin
      pcnt <= '0;
      ucnt <= '0;
    end else if (unit_tick) begin
      pcnt <= '0;
      ucnt <= ucnt + 2'd1;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Serial Morse keyer: accepts a 5-symbol code and keys it with standard timing.
// Handshake: a code transfers on a clk edge where in_valid and in_ready are both high.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s1,
  input  logic         s2,
  input  logic         s3,
  input  logic         s4,
  input  logic         s5,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         abort,
  output logic         key,
  output logic         busy,
  output logic         done,
  output morse_state_t dbg_state
);

  morse_state_t state, next_state;
  logic [4:0]   sreg;
  logic [2:0]   idx;
  logic [1:0]   target_units;
  logic         restart;
  logic         expired;
  logic         almost_expired;

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;
  assign restart   = (state == IDLE) || (next_state != state);

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .restart       (restart),
    .target_units  (target_units),
    .expired       (expired),
    .almost_expired(almost_expired)
  );

  always_comb begin
    next_state   = state;
    target_units = CHAR_GAP_UNITS;
    case (state)
      IDLE: begin
        if (in_valid) next_state = MARK;
      end
      MARK: begin
        target_units = mark_units(sreg[0]);
        if (expired) next_state = (idx < LAST_SYMBOL) ? GAP : CHAR_GAP;
      end
      GAP: begin
        target_units = GAP_UNITS;
        if (expired) next_state = MARK;
      end
      CHAR_GAP: begin
        target_units = CHAR_GAP_UNITS;
        if (expired) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (abort && (state != IDLE)) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      key   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sreg  <= '0;
      idx   <= '0;
    end else begin
      state <= next_state;
      key   <= (next_state == MARK);
      busy  <= (next_state != IDLE);
      // Set one cycle early so the registered pulse lands on the last char-gap cycle.
      done  <= (state == CHAR_GAP) && almost_expired && (next_state == CHAR_GAP);
      if ((state == IDLE) && in_valid) begin
        sreg <= {s5, s4, s3, s2, s1};
        idx  <= '0;
      end else if (next_state == IDLE) begin
        sreg <= '0;
        idx  <= '0;
      end else if ((state == GAP) && expired) begin
        sreg <= sreg >> 1;
        idx  <= idx + 3'd1;
      end
    end
  end

endmodule
